// File: rtl/conv_pkg.sv
// Shared definitions for the byte-serial link: the 32-to-8 serialiser and the
// 8-to-32 packer both take their default widths and byte order from here.
package conv_pkg;

    localparam int DEF_BYTE_W    = 8;
    localparam int DEF_WORD_W    = 32;
    localparam int N_BYTES       = DEF_WORD_W / DEF_BYTE_W;
    localparam int CNT_W         = $clog2(N_BYTES);
    localparam bit DEF_MSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Lowest bit index of byte slot 'slot' inside a word; slot 0 is the first
    // byte on the wire, placed at the top or bottom of the word by msb_first.
    function automatic int slot_lsb(input int slot, input bit msb_first,
                                    input int byte_w, input int word_w);
        if (msb_first)
            return word_w - (slot + 1) * byte_w;
        else
            return slot * byte_w;
    endfunction

endpackage

// File: rtl/conv_8_32.sv
// Byte-to-word packer: collects BYTE_W-bit bytes into WORD_W-bit words and
// pulses valid_out for one cycle per completed word. first_in realigns the
// word boundary, discarding any partial word and flagging it on align_err.
module conv_8_32
    import conv_pkg::*;
#(
    parameter int BYTE_W    = DEF_BYTE_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter bit MSB_FIRST = DEF_MSB_FIRST,
    localparam int N_SLOTS  = WORD_W / BYTE_W,
    localparam int SLOT_CW  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [BYTE_W-1:0]  data_in,
    input  logic               first_in,
    output logic               valid_out,
    output logic [WORD_W-1:0]  data_out,
    output logic [SLOT_CW-1:0] byte_cnt,
    output logic               align_err
);

    localparam logic [SLOT_CW-1:0] LAST_SLOT = SLOT_CW'(N_SLOTS - 1);

    state_t              state_q;
    logic [SLOT_CW-1:0]  cnt_q;
    logic [WORD_W-1:0]   asm_q;
    logic [WORD_W-1:0]   data_out_q;
    logic                valid_q;
    logic                align_q;

    logic [WORD_W-1:0]   merged_d;
    logic [WORD_W-1:0]   restart_d;

    // Write one byte into its slot of a word, leaving other slots untouched.
    function automatic logic [WORD_W-1:0] place(input logic [WORD_W-1:0] w,
                                                input int slot,
                                                input logic [BYTE_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = w;
        r[slot_lsb(slot, MSB_FIRST, BYTE_W, WORD_W) +: BYTE_W] = b;
        return r;
    endfunction

    // Candidate assembly values: current byte appended to the partial word,
    // or current byte starting a fresh word in slot 0 with other slots cleared.
    always_comb begin
        merged_d  = place(asm_q, int'(cnt_q), data_in);
        restart_d = place('0, 0, data_in);
    end

    // Packer FSM: slot counter, assembly register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            asm_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            align_q <= 1'b0;
            if (valid_in) begin
                case (state_q)
                    IDLE: begin
                        asm_q   <= restart_d;
                        cnt_q   <= SLOT_CW'(1);
                        state_q <= COLLECT;
                    end
                    COLLECT: begin
                        if (first_in) begin
                            // Realign: drop the partial word, this byte is slot 0.
                            align_q <= 1'b1;
                            asm_q   <= restart_d;
                            cnt_q   <= SLOT_CW'(1);
                        end else if (cnt_q == LAST_SLOT) begin
                            data_out_q <= merged_d;
                            valid_q    <= 1'b1;
                            asm_q      <= '0;
                            cnt_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            asm_q <= merged_d;
                            cnt_q <= cnt_q + SLOT_CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_out_q;
    assign byte_cnt  = cnt_q;
    assign align_err = align_q;

endmodule

// File: tb/tb_conv_8_32.sv
// Bench for conv_8_32: drives one byte stream into an MSB-first and an
// LSB-first packer; a reference model queues expected words and realign
// events, and a monitor compares them as the packers present outputs.
module tb_conv_8_32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        first_in = 1'b0;
    logic [7:0]  data_in = 8'h00;

    logic        vo_m, ae_m, vo_l, ae_l;
    logic [31:0] do_m, do_l;
    logic [1:0]  bc_m, bc_l;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cur[$];
    logic [31:0] expm_q[$];
    logic [31:0] expl_q[$];
    bit          align_q[$];
    logic [31:0] hold_m = 32'h0;
    logic [31:0] hold_l = 32'h0;

    conv_8_32 #(.BYTE_W(8), .WORD_W(32), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .first_in(first_in), .valid_out(vo_m), .data_out(do_m),
        .byte_cnt(bc_m), .align_err(ae_m)
    );

    conv_8_32 #(.BYTE_W(8), .WORD_W(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .first_in(first_in), .valid_out(vo_l), .data_out(do_l),
        .byte_cnt(bc_l), .align_err(ae_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model to the state
    // the packers will hold after the coming rising edge.
    task automatic step(input bit r, input bit v, input bit f, input logic [7:0] d);
        logic [31:0] wm, wl;
        @(negedge clk);
        reset    = r;
        valid_in = v;
        first_in = f;
        data_in  = d;
        if (r) begin
            cur.delete();
        end else if (v) begin
            if (f && cur.size() > 0) begin
                align_q.push_back(1'b1);
                cur.delete();
            end
            cur.push_back(d);
            if (cur.size() == 4) begin
                wm = 32'h0;
                wl = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    wm = {wm[23:0], cur[k]};
                    wl = wl | (32'(cur[k]) << (8 * k));
                end
                expm_q.push_back(wm);
                expl_q.push_back(wl);
                cur.delete();
            end
        end
    endtask

    task automatic byte_in(input logic [7:0] d, input bit f);
        step(1'b0, 1'b1, f, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare packer outputs shortly after each rising edge.
    always @(posedge clk) begin
        bit exp_v, exp_a;
        #2;
        if (reset) begin
            check("rst_valid_m", 32'(vo_m), 32'd0);
            check("rst_valid_l", 32'(vo_l), 32'd0);
            check("rst_data_m", do_m, 32'h0);
            check("rst_data_l", do_l, 32'h0);
            check("rst_align_m", 32'(ae_m), 32'd0);
            check("rst_cnt_m", 32'(bc_m), 32'd0);
            check("rst_cnt_l", 32'(bc_l), 32'd0);
            hold_m = 32'h0;
            hold_l = 32'h0;
        end else begin
            exp_v = (expm_q.size() > 0);
            check("valid_out_m", 32'(vo_m), 32'(exp_v));
            check("valid_out_l", 32'(vo_l), 32'(exp_v));
            if (exp_v) begin
                hold_m = expm_q.pop_front();
                hold_l = expl_q.pop_front();
            end
            check("data_out_m", do_m, hold_m);
            check("data_out_l", do_l, hold_l);
            exp_a = (align_q.size() > 0);
            if (exp_a) void'(align_q.pop_front());
            check("align_err_m", 32'(ae_m), 32'(exp_a));
            check("align_err_l", 32'(ae_l), 32'(exp_a));
            check("byte_cnt_m", 32'(bc_m), 32'(cur.size()));
            check("byte_cnt_l", 32'(bc_l), 32'(cur.size()));
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(2);

        // Consecutive bytes.
        byte_in(8'hAA, 1'b0); byte_in(8'hBB, 1'b0);
        byte_in(8'hCC, 1'b0); byte_in(8'hDD, 1'b0);
        idle(3);

        // Same bytes with gaps of 1..3 idle cycles.
        byte_in(8'hAA, 1'b0); idle(1);
        byte_in(8'hBB, 1'b0); idle(2);
        byte_in(8'hCC, 1'b0); idle(3);
        byte_in(8'hDD, 1'b0); idle(3);

        // Realignment in the middle of a word.
        byte_in(8'h11, 1'b0); byte_in(8'h22, 1'b0);
        byte_in(8'h33, 1'b1); byte_in(8'h44, 1'b0);
        byte_in(8'h55, 1'b0); byte_in(8'h66, 1'b0);
        idle(2);

        // first_in on a word's first byte is not a realignment.
        byte_in(8'h77, 1'b1); byte_in(8'h88, 1'b0);
        byte_in(8'h99, 1'b0); byte_in(8'hA0, 1'b0);
        idle(2);

        // Reset with a partial word held.
        byte_in(8'h01, 1'b0); byte_in(8'h02, 1'b0); byte_in(8'h03, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        byte_in(8'h0A, 1'b0); byte_in(8'h0B, 1'b0);
        byte_in(8'h0C, 1'b0); byte_in(8'h0D, 1'b0);
        idle(2);

        // Back-to-back words with no bubble.
        for (int i = 0; i < 8; i++) byte_in(8'(i), 1'b0);
        idle(3);

        // Randomized traffic including realigns and occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 100) == 0, ($urandom % 10) < 7,
                 ($urandom % 8) == 0, 8'($urandom));
        end
        idle(4);

        check("pending_words", 32'(expm_q.size()), 32'd0);
        check("pending_align", 32'(align_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
